execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- EX stage of the 5-stage MIPS pipeline; sits directly upstream of memory_cycle and drives its M-side inputs.
- Performs operand forwarding, ALU operation, branch resolution and store-data selection.
- Runs a multi-cycle signed multiply (MULT into HI/LO) with a stall handshake to the hazard unit.
- Registers the E/M pipeline register on the clock edge.

Parameters:
- MUL_CYCLES, 32, number of BUSY cycles of the iterative shift-add multiplier (power of two, 2..32).

Ports:
- clock  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-low.
- regwriteE, memreadE, memwriteE, isloadE, branchE, alusrcE  in  1 each  ID/E control bits.
- aluopE  in  4  ALU operation code (package constants).
- rd1E, rd2E  in  32 each  register-file read data.
- immE  in  32  sign-extended immediate.
- shamtE  in  5  shift amount.
- rdE  in  5  destination register.
- pcplus4E  in  32  PC+4 of the instruction in E.
- forwardAE, forwardBE  in  2 each  00 = register file, 01 = resultW, 10 = aluresultM forward.
- resultW  in  32  writeback-stage result.
- aluresult_fwdM  in  32  aluresult currently in M.
- pcsrcE  out  1  branch taken (combinational).
- branchtargetE  out  32  pcplus4E + (immE<<2) (combinational).
- stallE  out  1  multiply in progress; upstream must hold F/D/E.
- regwriteM, memreadM, memwriteM, isloadM  out  1 each  registered control.
- aluresultM, writedataM, pcplus4M  out  32 each  registered data.
- rdM  out  5  registered destination.

Behaviour:
- Reset (rst=0 at posedge): all M outputs 0, HI=LO=0, FSM to IDLE, counter 0, stallE=0. A multiply in flight is abandoned.
- Operand A = mux(forwardAE). Operand B = alusrcE ? immE : mux(forwardBE). writedataE = mux(forwardBE), never the immediate. Code 11 on a forward select behaves as 00.
- ALU ops (package codes):
  - ADD 0, SUB 1: 32-bit wrap, no overflow trap.
  - AND 2, OR 3, XOR 4, NOR 5.
  - SLT 6 (signed), SLTU 7 (unsigned); result 1 or 0.
  - SLL 8, SRL 9, SRA 10: shift B by shamtE.
  - LUI 11: B<<16.
  - MULT 12: result 0; starts the multiplier.
  - MFHI 13 → HI, MFLO 14 → LO.
  - Undefined code 15 → result 0.
- zero = (A−B)==0. pcsrcE = branchE & zero (BEQ only).
- Latency: one cycle, E → M register, for all ops except MULT.
- Multiplier FSM:
  - IDLE: if aluopE==MULT, latch |A|, |B| and sign = A[31]^B[31]; counter←0; go to BUSY. stallE=1 in this cycle.
  - BUSY: each cycle add the multiplicand to the 64-bit product when the multiplier LSB is 1, then shift; counter+1. stallE=1 while counter<MUL_CYCLES−1.
  - At counter==MUL_CYCLES−1: stallE=0; at that edge {HI,LO} ← sign ? −product : product; go to IDLE.
  - The MULT instruction occupies E for 1+MUL_CYCLES cycles.
- While stallE=1, the E/M register loads a bubble: regwriteM, memreadM, memwriteM, isloadM = 0; data fields are don't-care but held at their previous values.
- On the final MULT cycle the register loads the MULT itself with regwriteM=0. The next instruction (e.g. MFHI) sees the updated HI/LO.
- In IDLE, operands are sampled only while aluopE==MULT; back-to-back MULTs restart cleanly after returning to IDLE.
- Control and data outputs of memory_cycle's inputs are fully registered. pcsrcE and branchtargetE are the only combinational outputs.

Decomposition:
- Shared package mips_pkg: 4-bit ALU op constants (ALU_ADD..ALU_MFLO), 2-bit forward-select constants (FWD_RF, FWD_W, FWD_M), multiplier state enum (IDLE, BUSY).
- One natural sub-module: mult_iter, holding the FSM, counter and product registers with start, busy/done and hi/lo outputs. Everything else stays in execute_cycle.

Test Plan:
- Reset: hold rst=0 two cycles with random inputs → all M outputs 0 and stallE=0; release rst → first ADD rd1E=5, rd2E=7 gives aluresultM=12 one cycle later.
- Forwarding: forwardAE=10, aluresult_fwdM=0x100, forwardBE=01, resultW=0x20, SUB → aluresultM=0xE0. Store with alusrcE=1, immE=4 → writedataM=resultW, aluresultM=A+4.
- Branch: branchE=1 with A=B=0x55, pcplus4E=0x40, immE=3 → pcsrcE=1, branchtargetE=0x4C. Same with A≠B → pcsrcE=0.
- Multiply: MULT A=−3, B=7 → stallE high exactly 32 cycles with regwriteM=0 throughout; following MFLO → aluresultM=0xFFFFFFEB; MFHI → 0xFFFFFFFF.
- Reset mid-multiply: assert rst at BUSY cycle 10 → next cycle stallE=0, HI=LO=0; a subsequent MFHI returns 0.
- Shifts and compares: SRA B=0x80000000 with shamtE=4 → 0xF8000000. SLTU A=1, B=0xFFFFFFFF → 1. SLT with the same operands → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage constants, types and helpers.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MULT = 4'd12;
  localparam logic [3:0] ALU_MFHI = 4'd13;
  localparam logic [3:0] ALU_MFLO = 4'd14;

  // Forward-select codes (3 falls back to the register file)
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {IDLE, BUSY} mul_state_t;

  // E/M pipeline register payload
  typedef struct packed {
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            isload;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] writedata;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rd;
  } em_t;

  // Two's-complement magnitude; 0x80000000 maps to itself as unsigned
  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/E inputs and E/M outputs of the execute stage.
interface execute_cycle_if;
  logic        regwriteE, memreadE, memwriteE, isloadE, branchE, alusrcE;
  logic [3:0]  aluopE;
  logic [31:0] rd1E, rd2E, immE, pcplus4E, resultW, aluresult_fwdM;
  logic [4:0]  shamtE, rdE;
  logic [1:0]  forwardAE, forwardBE;
  logic        pcsrcE, stallE;
  logic [31:0] branchtargetE;
  logic        regwriteM, memreadM, memwriteM, isloadM;
  logic [31:0] aluresultM, writedataM, pcplus4M;
  logic [4:0]  rdM;

  modport slave (
    input  regwriteE, memreadE, memwriteE, isloadE, branchE, alusrcE, aluopE,
           rd1E, rd2E, immE, shamtE, rdE, pcplus4E, forwardAE, forwardBE,
           resultW, aluresult_fwdM,
    output pcsrcE, branchtargetE, stallE, regwriteM, memreadM, memwriteM,
           isloadM, aluresultM, writedataM, pcplus4M, rdM
  );

  modport master (
    output regwriteE, memreadE, memwriteE, isloadE, branchE, alusrcE, aluopE,
           rd1E, rd2E, immE, shamtE, rdE, pcplus4E, forwardAE, forwardBE,
           resultW, aluresult_fwdM,
    input  pcsrcE, branchtargetE, stallE, regwriteM, memreadM, memwriteM,
           isloadM, aluresultM, writedataM, pcplus4M, rdM
  );
endinterface

// File: rtl/execute_cycle_mult_iter.sv
// Iterative signed shift-add multiplier producing HI/LO.
module mult_iter
  import mips_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall_c,
  output logic            done_c,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int unsigned STEP = XLEN / MUL_CYCLES;
  localparam int unsigned CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  mul_state_t        state, state_n;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand, mcand_n, prod, prod_n;
  logic [XLEN-1:0]   mplier, mplier_n;
  logic              sign;

  // State register
  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and stall/done strobes
  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: if (start) begin
        stall_c = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        stall_c = (cnt != LAST);
        if (cnt == LAST) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // STEP multiplier bits consumed per BUSY cycle
  always_comb begin
    prod_n   = prod;
    mcand_n  = mcand;
    mplier_n = mplier;
    for (int i = 0; i < int'(STEP); i++) begin
      if (mplier_n[0]) prod_n = prod_n + mcand_n;
      mcand_n  = mcand_n << 1;
      mplier_n = mplier_n >> 1;
    end
  end

  // Operand latch, accumulation and HI/LO writeback
  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      sign   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= {XLEN'(0), abs32(a)};
          mplier <= abs32(b);
          prod   <= '0;
          sign   <= a[XLEN-1] ^ b[XLEN-1];
          cnt    <= '0;
        end
        BUSY: begin
          prod   <= prod_n;
          mcand  <= mcand_n;
          mplier <= mplier_n;
          cnt    <= CW'(cnt + CW'(1));
          if (cnt == LAST) {hi, lo} <= sign ? (~prod_n + (2*XLEN)'(1)) : prod_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/execute_cycle.sv
// MIPS EX stage: forwarding, ALU, branch resolution, multiply and E/M register.
module execute_cycle
  import mips_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            rst,
  execute_cycle_if.slave  bus
);
  logic [XLEN-1:0] src_a, src_b, fwd_b, alu_result, hi, lo;
  logic            mul_start, mul_stall_c, mul_done_c;
  em_t             em, em_n;

  // Operand forwarding and ALU
  always_comb begin
    case (bus.forwardAE)
      FWD_W:   src_a = bus.resultW;
      FWD_M:   src_a = bus.aluresult_fwdM;
      default: src_a = bus.rd1E;
    endcase
    case (bus.forwardBE)
      FWD_W:   fwd_b = bus.resultW;
      FWD_M:   fwd_b = bus.aluresult_fwdM;
      default: fwd_b = bus.rd2E;
    endcase
    src_b = bus.alusrcE ? bus.immE : fwd_b;
    case (bus.aluopE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_NOR:  alu_result = ~(src_a | src_b);
      ALU_SLT:  alu_result = ($signed(src_a) < $signed(src_b)) ? XLEN'(1) : XLEN'(0);
      ALU_SLTU: alu_result = (src_a < src_b) ? XLEN'(1) : XLEN'(0);
      ALU_SLL:  alu_result = src_b << bus.shamtE;
      ALU_SRL:  alu_result = src_b >> bus.shamtE;
      ALU_SRA:  alu_result = XLEN'($signed(src_b) >>> bus.shamtE);
      ALU_LUI:  alu_result = src_b << 16;
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  assign bus.pcsrcE        = bus.branchE & ((src_a - src_b) == '0);
  assign bus.branchtargetE = bus.pcplus4E + (bus.immE << 2);

  // Start is masked during reset so stall stays low with arbitrary inputs
  assign mul_start  = rst & (bus.aluopE == ALU_MULT);
  assign bus.stallE = mul_stall_c;

  mult_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mult (
    .clock   (clock),
    .rst     (rst),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .stall_c (mul_stall_c),
    .done_c  (mul_done_c),
    .hi      (hi),
    .lo      (lo)
  );

  // Next E/M payload; the completing MULT never writes the register file
  always_comb begin
    em_n           = '0;
    em_n.regwrite  = bus.regwriteE & ~mul_done_c;
    em_n.memread   = bus.memreadE;
    em_n.memwrite  = bus.memwriteE;
    em_n.isload    = bus.isloadE;
    em_n.aluresult = alu_result;
    em_n.writedata = fwd_b;
    em_n.pcplus4   = bus.pcplus4E;
    em_n.rd        = bus.rdE;
  end

  // E/M register; a stall inserts a bubble and holds the data fields
  always_ff @(posedge clock) begin
    if (!rst) begin
      em <= '0;
    end else if (mul_stall_c) begin
      em.regwrite <= 1'b0;
      em.memread  <= 1'b0;
      em.memwrite <= 1'b0;
      em.isload   <= 1'b0;
    end else begin
      em <= em_n;
    end
  end

  assign bus.regwriteM  = em.regwrite;
  assign bus.memreadM   = em.memread;
  assign bus.memwriteM  = em.memwrite;
  assign bus.isloadM    = em.isload;
  assign bus.aluresultM = em.aluresult;
  assign bus.writedataM = em.writedata;
  assign bus.pcplus4M   = em.pcplus4;
  assign bus.rdM        = em.rd;
endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle against an arithmetic reference model.
module tb_execute_cycle;
  localparam int unsigned MULC = 32;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] mhi = '0, mlo = '0;

  execute_cycle_if bus();

  execute_cycle #(.MUL_CYCLES(MULC)) dut (.clock(clock), .rst(rst), .bus(bus));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.regwriteE = 1'b1; bus.memreadE = 1'b0; bus.memwriteE = 1'b0; bus.isloadE = 1'b0;
    bus.branchE = 1'b0; bus.alusrcE = 1'b0; bus.aluopE = op;
    bus.rd1E = a; bus.rd2E = b; bus.immE = '0; bus.shamtE = '0; bus.rdE = 5'd3;
    bus.pcplus4E = 32'h1000; bus.forwardAE = 2'b00; bus.forwardBE = 2'b00;
    bus.resultW = '0; bus.aluresult_fwdM = '0;
  endtask

  // Reference ALU from the instruction definitions
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] fill;
    fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return (b >> sh) | fill;
      4'd11: return {b[15:0], 16'h0};
      4'd13: return mhi;
      4'd14: return mlo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      bus.regwriteE = 1'b1; bus.memreadE = 1'b1; bus.memwriteE = 1'b1; bus.isloadE = 1'b1;
      bus.branchE = 1'($urandom); bus.alusrcE = 1'($urandom);
      bus.aluopE = 4'($urandom); bus.rd1E = $urandom; bus.rd2E = $urandom;
      bus.immE = $urandom; bus.shamtE = 5'($urandom); bus.rdE = 5'($urandom);
      bus.pcplus4E = $urandom; bus.forwardAE = 2'($urandom); bus.forwardBE = 2'($urandom);
      bus.resultW = $urandom; bus.aluresult_fwdM = $urandom;
      step();
      total++;
      if (bus.stallE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stallE); end
      total++;
      if ({bus.regwriteM, bus.memreadM, bus.memwriteM, bus.isloadM, bus.aluresultM,
           bus.writedataM, bus.pcplus4M, bus.rdM} !== '0) begin
        bad++; $display("FAIL reset_m_outputs alu=%h wd=%h pc=%h rd=%h", bus.aluresultM,
                        bus.writedataM, bus.pcplus4M, bus.rdM);
      end
    end
    set_instr(4'd0, 32'd5, 32'd7);
    rst = 1'b1;
    step();
    total++;
    if (bus.aluresultM !== 32'd12) begin bad++; $display("FAIL first_add got=%h want=0000000c", bus.aluresultM); end
  endtask

  task automatic test_forwarding();
    set_instr(4'd1, 32'hDEAD, 32'hBEEF);
    bus.forwardAE = 2'b10; bus.aluresult_fwdM = 32'h100;
    bus.forwardBE = 2'b01; bus.resultW = 32'h20;
    step();
    total++;
    if (bus.aluresultM !== 32'hE0) begin bad++; $display("FAIL fwd_sub got=%h want=000000e0", bus.aluresultM); end
    set_instr(4'd0, 32'hDEAD, 32'hBEEF);
    bus.forwardAE = 2'b10; bus.aluresult_fwdM = 32'h100;
    bus.forwardBE = 2'b01; bus.resultW = 32'h20;
    bus.alusrcE = 1'b1; bus.immE = 32'd4; bus.memwriteE = 1'b1; bus.regwriteE = 1'b0;
    step();
    total++;
    if (bus.writedataM !== 32'h20 || bus.aluresultM !== 32'h104 || bus.memwriteM !== 1'b1) begin
      bad++; $display("FAIL store wd=%h alu=%h mw=%b want 00000020 00000104 1",
                      bus.writedataM, bus.aluresultM, bus.memwriteM);
    end
  endtask

  task automatic test_branch();
    set_instr(4'd1, 32'h55, 32'h55);
    bus.branchE = 1'b1; bus.pcplus4E = 32'h40; bus.immE = 32'd3; bus.regwriteE = 1'b0;
    #1;
    total++;
    if (bus.pcsrcE !== 1'b1 || bus.branchtargetE !== 32'h4C) begin
      bad++; $display("FAIL branch_taken pcsrc=%b tgt=%h want 1 0000004c", bus.pcsrcE, bus.branchtargetE);
    end
    bus.rd2E = 32'h56;
    #1;
    total++;
    if (bus.pcsrcE !== 1'b0) begin bad++; $display("FAIL branch_not_taken got=%b want=0", bus.pcsrcE); end
    step();
  endtask

  task automatic test_shift_compare();
    set_instr(4'd10, 32'h0, 32'h8000_0000);
    bus.shamtE = 5'd4;
    step();
    total++;
    if (bus.aluresultM !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want=f8000000", bus.aluresultM); end
    set_instr(4'd7, 32'd1, 32'hFFFF_FFFF);
    step();
    total++;
    if (bus.aluresultM !== 32'd1) begin bad++; $display("FAIL sltu got=%h want=00000001", bus.aluresultM); end
    set_instr(4'd6, 32'd1, 32'hFFFF_FFFF);
    step();
    total++;
    if (bus.aluresultM !== 32'd0) begin bad++; $display("FAIL slt got=%h want=00000000", bus.aluresultM); end
  endtask

  // One MULT followed by MFLO and MFHI, checked against a 64-bit product
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     n;
    p = longint'($signed(a)) * longint'($signed(b));
    set_instr(4'd12, a, b);
    #1;
    n = 0;
    while (bus.stallE === 1'b1 && n < 200) begin
      n++;
      step();
      total++;
      if (bus.regwriteM !== 1'b0) begin bad++; $display("FAIL mult_bubble_regwrite cycle=%0d got=%b want=0", n, bus.regwriteM); end
    end
    total++;
    if (n != int'(MULC)) begin bad++; $display("FAIL mult_stall_len got=%0d want=%0d", n, MULC); end
    step();
    total++;
    if (bus.regwriteM !== 1'b0) begin bad++; $display("FAIL mult_final_regwrite got=%b want=0", bus.regwriteM); end
    mhi = p[63:32];
    mlo = p[31:0];
    set_instr(4'd14, 32'h0, 32'h0);
    step();
    total++;
    if (bus.aluresultM !== mlo) begin bad++; $display("FAIL mflo got=%h want=%h", bus.aluresultM, mlo); end
    set_instr(4'd13, 32'h0, 32'h0);
    step();
    total++;
    if (bus.aluresultM !== mhi) begin bad++; $display("FAIL mfhi got=%h want=%h", bus.aluresultM, mhi); end
  endtask

  task automatic test_mult();
    run_mult(32'hFFFF_FFFD, 32'd7);
  endtask

  task automatic test_reset_mid_mult();
    set_instr(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    for (int c = 0; c < 10; c++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mhi = '0; mlo = '0;
    set_instr(4'd13, 32'h0, 32'h0);
    #1;
    total++;
    if (bus.stallE !== 1'b0) begin bad++; $display("FAIL reset_mid_stall got=%b want=0", bus.stallE); end
    step();
    total++;
    if (bus.aluresultM !== 32'h0) begin bad++; $display("FAIL reset_mid_hi got=%h want=00000000", bus.aluresultM); end
    set_instr(4'd14, 32'h0, 32'h0);
    step();
    total++;
    if (bus.aluresultM !== 32'h0) begin bad++; $display("FAIL reset_mid_lo got=%h want=00000000", bus.aluresultM); end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b, wd;
    logic [3:0]  op;
    logic [31:0] exp_res;
    for (int i = 0; i < 200; i++) begin
      do op = 4'($urandom); while (op == 4'd12);
      bus.aluopE = op;
      bus.regwriteE = 1'($urandom); bus.memreadE = 1'($urandom);
      bus.memwriteE = 1'($urandom); bus.isloadE = 1'($urandom);
      bus.branchE = 1'($urandom); bus.alusrcE = 1'($urandom);
      bus.rd1E = $urandom; bus.rd2E = ($urandom_range(0, 3) == 0) ? bus.rd1E : $urandom;
      bus.immE = $urandom; bus.shamtE = 5'($urandom); bus.rdE = 5'($urandom);
      bus.pcplus4E = $urandom; bus.forwardAE = 2'($urandom); bus.forwardBE = 2'($urandom);
      bus.resultW = $urandom; bus.aluresult_fwdM = $urandom;
      a  = (bus.forwardAE == 2'b01) ? bus.resultW : (bus.forwardAE == 2'b10) ? bus.aluresult_fwdM : bus.rd1E;
      wd = (bus.forwardBE == 2'b01) ? bus.resultW : (bus.forwardBE == 2'b10) ? bus.aluresult_fwdM : bus.rd2E;
      b  = bus.alusrcE ? bus.immE : wd;
      exp_res = ref_alu(op, a, b, bus.shamtE);
      #1;
      total++;
      if (bus.pcsrcE !== (bus.branchE && a == b) || bus.branchtargetE !== bus.pcplus4E + 4 * bus.immE
          || bus.stallE !== 1'b0) begin
        bad++; $display("FAIL rand_comb i=%0d pcsrc=%b tgt=%h stall=%b", i, bus.pcsrcE, bus.branchtargetE, bus.stallE);
      end
      step();
      total++;
      if (bus.aluresultM !== exp_res || bus.writedataM !== wd || bus.regwriteM !== bus.regwriteE
          || bus.memreadM !== bus.memreadE || bus.memwriteM !== bus.memwriteE || bus.isloadM !== bus.isloadE
          || bus.pcplus4M !== bus.pcplus4E || bus.rdM !== bus.rdE) begin
        bad++; $display("FAIL rand_alu i=%0d op=%0d alu=%h want=%h wd=%h want=%h", i, op,
                        bus.aluresultM, exp_res, bus.writedataM, wd);
      end
    end
  endtask

  task automatic test_random_mult();
    run_mult(32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) run_mult($urandom, $urandom);
  endtask

  initial begin
    set_instr(4'd0, 32'h0, 32'h0);
    test_reset();
    test_forwarding();
    test_branch();
    test_shift_compare();
    test_mult();
    test_reset_mid_mult();
    test_random_alu();
    test_random_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
